// File: rtl/regfile_multiport.sv
// MIPS general-purpose register file: NUM_RD combinational read ports with write bypass,
// two write ports (A = ALU, B = load), r0 hard-wired to zero, and a sweep-clear FSM.
module regfile_multiport #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int V0_IDX = 2,
    parameter int A0_IDX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
    output logic [NUM_RD*DATA_W-1:0]   rdData,
    input  logic                       weA,
    input  logic [ADDR_W-1:0]          waddrA,
    input  logic [DATA_W-1:0]          wdataA,
    input  logic                       weB,
    input  logic [ADDR_W-1:0]          waddrB,
    input  logic [DATA_W-1:0]          wdataB,
    input  logic                       clearReq,
    output logic                       busy,
    output logic                       writeDropped,
    output logic [DATA_W-1:0]          v0,
    output logic [DATA_W-1:0]          a0
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SWEEP = 1'b1;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              write_dropped_q, write_dropped_d;

    logic is_idle;
    logic wr_a_valid;
    logic wr_b_valid;

    assign is_idle    = (state_q == ST_IDLE);
    assign wr_a_valid = weA && (waddrA != '0);
    assign wr_b_valid = weB && (waddrB != '0);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        regs_d          = regs_q;
        state_d         = state_q;
        ptr_d           = ptr_q;
        write_dropped_d = !is_idle && (wr_a_valid || wr_b_valid);

        if (is_idle) begin
            // Port B is applied last so it wins an address collision.
            if (wr_a_valid) regs_d[waddrA] = wdataA;
            if (wr_b_valid) regs_d[waddrB] = wdataB;
            if (clearReq) begin
                state_d = ST_SWEEP;
                ptr_d   = FIRST_IDX;
            end
        end else begin
            regs_d[ptr_q] = '0;
            ptr_d         = ptr_q + 1'b1;
            if (ptr_q == LAST_IDX) state_d = ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the array is reset because software relies on a cleared file after reset.
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            state_q         <= ST_IDLE;
            ptr_q           <= FIRST_IDX;
            write_dropped_q <= 1'b0;
        end else begin
            regs_q          <= regs_d;
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            write_dropped_q <= write_dropped_d;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_val;

        assign rd_addr = rdAddr[k*ADDR_W +: ADDR_W];

        // Bypass only applies while idle, since sweep discards the writes.
        always_comb begin
            if (rd_addr == '0)                              rd_val = '0;
            else if (is_idle && weB && (waddrB == rd_addr)) rd_val = wdataB;
            else if (is_idle && weA && (waddrA == rd_addr)) rd_val = wdataA;
            else                                            rd_val = regs_q[rd_addr];
        end

        assign rdData[k*DATA_W +: DATA_W] = rd_val;
    end

    assign busy         = (state_q == ST_SWEEP);
    assign writeDropped = write_dropped_q;
    assign v0           = regs_q[V0_IDX];
    assign a0           = regs_q[A0_IDX];

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: expected values are queued when stimulus is
// driven and popped against DUT outputs sampled on the falling clock edge.
module tb_regfile_multiport;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_bus;
    logic [NUM_RD*DATA_W-1:0] rd_data_bus;
    logic                     we_a, we_b, clear_req;
    logic [ADDR_W-1:0]        waddr_a, waddr_b;
    logic [DATA_W-1:0]        wdata_a, wdata_b;
    logic                     busy, write_dropped;
    logic [DATA_W-1:0]        v0, a0;

    logic [ADDR_W-1:0] ra [NUM_RD];

    typedef struct {
        string             tag;
        logic [DATA_W-1:0] exp;
    } sb_entry_t;

    sb_entry_t sb [$];
    int n_checks = 0;
    int n_fail   = 0;
    int busy_cycles;

    regfile_multiport #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD), .V0_IDX(2), .A0_IDX(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rdAddr(rd_addr_bus), .rdData(rd_data_bus),
        .weA(we_a), .waddrA(waddr_a), .wdataA(wdata_a),
        .weB(we_b), .waddrB(waddr_b), .wdataB(wdata_b),
        .clearReq(clear_req), .busy(busy), .writeDropped(write_dropped),
        .v0(v0), .a0(a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) rd_addr_bus[k*ADDR_W +: ADDR_W] = ra[k];
    end

    function automatic logic [DATA_W-1:0] rd(input int k);
        return rd_data_bus[k*DATA_W +: DATA_W];
    endfunction

    task automatic expect_val(input string tag, input logic [DATA_W-1:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check(input logic [DATA_W-1:0] obs);
        sb_entry_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <queued entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we_a = 1'b0; we_b = 1'b0; clear_req = 1'b0;
        waddr_a = '0; waddr_b = '0; wdata_a = '0; wdata_b = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        ra[0] = '0; ra[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Reset state
        ra[0] = 5'd5; ra[1] = 5'd31;
        expect_val("reset_rd0", 32'h0);
        expect_val("reset_rd1", 32'h0);
        expect_val("reset_v0", 32'h0);
        expect_val("reset_a0", 32'h0);
        expect_val("reset_busy", 32'h0);
        expect_val("reset_wdrop", 32'h0);
        @(negedge clk);
        check(rd(0)); check(rd(1)); check(v0); check(a0);
        check(32'(busy)); check(32'(write_dropped));
        tick();

        // Write with same-cycle bypass, then array read
        we_a = 1'b1; waddr_a = 5'd8; wdata_a = 32'hDEADBEEF; ra[0] = 5'd8;
        expect_val("bypass_a", 32'hDEADBEEF);
        @(negedge clk); check(rd(0));
        tick();
        idle_inputs();
        expect_val("stored_a", 32'hDEADBEEF);
        @(negedge clk); check(rd(0));
        tick();

        // Register zero is never written
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'h1234; ra[0] = 5'd0;
        expect_val("r0_same_cycle", 32'h0);
        @(negedge clk); check(rd(0));
        tick();
        idle_inputs();
        expect_val("r0_next_cycle", 32'h0);
        expect_val("r0_no_drop", 32'h0);
        @(negedge clk); check(rd(0)); check(32'(write_dropped));
        tick();

        // Collision: port B wins in bypass and in the array
        we_a = 1'b1; waddr_a = 5'd9; wdata_a = 32'h1;
        we_b = 1'b1; waddr_b = 5'd9; wdata_b = 32'h2; ra[0] = 5'd9;
        expect_val("collide_bypass", 32'h2);
        @(negedge clk); check(rd(0));
        tick();
        idle_inputs();
        expect_val("collide_stored", 32'h2);
        @(negedge clk); check(rd(0));
        tick();

        // Non-colliding dual write
        we_a = 1'b1; waddr_a = 5'd10; wdata_a = 32'hA;
        we_b = 1'b1; waddr_b = 5'd11; wdata_b = 32'hB;
        ra[0] = 5'd10; ra[1] = 5'd11;
        expect_val("dual_bypass_a", 32'hA);
        expect_val("dual_bypass_b", 32'hB);
        @(negedge clk); check(rd(0)); check(rd(1));
        tick();
        idle_inputs();
        expect_val("dual_stored_a", 32'hA);
        expect_val("dual_stored_b", 32'hB);
        @(negedge clk); check(rd(0)); check(rd(1));
        tick();

        // v0 tap has no bypass
        we_a = 1'b1; waddr_a = 5'd2; wdata_a = 32'h55; ra[1] = 5'd2;
        expect_val("v0_same_cycle", 32'h0);
        expect_val("v0_rd_bypass", 32'h55);
        @(negedge clk); check(v0); check(rd(1));
        tick();
        idle_inputs();
        expect_val("v0_after_edge", 32'h55);
        @(negedge clk); check(v0);
        tick();

        // Preload r1..r31 with their index, alternating write ports
        for (int i = 1; i < DEPTH; i++) begin
            idle_inputs();
            if (i % 2 == 1) begin we_a = 1'b1; waddr_a = ADDR_W'(i); wdata_a = 32'(i); end
            else            begin we_b = 1'b1; waddr_b = ADDR_W'(i); wdata_b = 32'(i); end
            tick();
        end
        idle_inputs();
        ra[0] = 5'd31; ra[1] = 5'd17;
        expect_val("preload_r31", 32'd31);
        expect_val("preload_r17", 32'd17);
        expect_val("preload_a0", 32'd4);
        @(negedge clk); check(rd(0)); check(rd(1)); check(a0);
        tick();

        // Sweep clear
        clear_req = 1'b1;
        expect_val("busy_before_sweep", 32'h0);
        @(negedge clk); check(32'(busy));
        tick();
        busy_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            idle_inputs();
            if (c == 10) begin
                we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'hFFFF;
                ra[0] = 5'd5; ra[1] = 5'd20;
            end else if (c == 11) begin
                we_b = 1'b1; waddr_b = 5'd25; wdata_b = 32'hBAD;
                ra[0] = 5'd25;
            end else if (c == 12) begin
                clear_req = 1'b1;
            end else if (c == 20) begin
                we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'h77;
            end
            @(negedge clk);
            if (c == 10) begin
                expect_val("sweep_r5_cleared", 32'h0);
                expect_val("sweep_r20_intact", 32'd20);
                check(rd(0)); check(rd(1));
            end else if (c == 11) begin
                expect_val("sweep_no_bypass", 32'd25);
                expect_val("wdrop_after_a", 32'h1);
                check(rd(0)); check(32'(write_dropped));
            end else if (c == 12) begin
                expect_val("wdrop_after_b", 32'h1);
                check(32'(write_dropped));
            end else if (c == 13) begin
                expect_val("wdrop_cleared", 32'h0);
                check(32'(write_dropped));
            end else if (c == 21) begin
                expect_val("wdrop_r0_write", 32'h0);
                check(32'(write_dropped));
            end
            if (!busy) break;
            busy_cycles++;
            tick();
        end
        expect_val("sweep_busy_cycles", 32'd31);
        check(32'(busy_cycles));
        tick();
        idle_inputs();
        ra[0] = 5'd7; ra[1] = 5'd25;
        expect_val("post_sweep_r7", 32'h0);
        expect_val("post_sweep_r25", 32'h0);
        expect_val("post_sweep_v0", 32'h0);
        @(negedge clk); check(rd(0)); check(rd(1)); check(v0);
        ra[0] = 5'd31; ra[1] = 5'd20;
        expect_val("post_sweep_r31", 32'h0);
        expect_val("post_sweep_r20", 32'h0);
        #1; check(rd(0)); check(rd(1));
        tick();

        // Reset in the middle of a sweep
        we_a = 1'b1; waddr_a = 5'd20; wdata_a = 32'd20;
        we_b = 1'b1; waddr_b = 5'd2;  wdata_b = 32'h77;
        tick();
        idle_inputs();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (15) tick();
        ra[0] = 5'd20; ra[1] = 5'd2;
        expect_val("midsweep_busy", 32'h1);
        expect_val("midsweep_r20", 32'd20);
        @(negedge clk); check(32'(busy)); check(rd(0));
        #1 rst_n = 1'b0;
        #1;
        expect_val("async_rst_busy", 32'h0);
        expect_val("async_rst_r20", 32'h0);
        expect_val("async_rst_v0", 32'h0);
        check(32'(busy)); check(rd(0)); check(v0);
        #2 rst_n = 1'b1;
        tick();
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'hA5; ra[0] = 5'd3;
        expect_val("post_rst_bypass", 32'hA5);
        @(negedge clk); check(rd(0));
        tick();
        idle_inputs();
        expect_val("post_rst_stored", 32'hA5);
        expect_val("post_rst_busy", 32'h0);
        @(negedge clk); check(rd(0)); check(32'(busy));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
